// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the icache (line reads) and dcache (line reads/writes).
// Optional MEM_ARB_RR_EN: round-robin tie-break; default build gives the dcache fixed priority.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128,
   parameter int BEATS  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req_valid,
   output logic              ic_req_ready,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_resp_valid,
   output logic [DATA_W-1:0] ic_resp_data,
   input  logic              dc_req_valid,
   output logic              dc_req_ready,
   input  logic              dc_req_rw,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic              dc_wdata_valid,
   output logic              dc_wdata_ready,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_resp_valid,
   output logic [DATA_W-1:0] dc_resp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_wdata_valid,
   input  logic              mem_wdata_ready,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data
);
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WDATA = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state;
   logic              owner_dc;
   logic              rw_lat;
   logic [ADDR_W-1:0] addr_lat;
   logic [CNT_W-1:0]  beat_cnt;
   logic              prefer_dc;
   logic              grant_dc;
   logic              grant_ic;
   logic              wdata_phase;
   logic              resp_phase;
   logic              beat_done;

`ifdef MEM_ARB_RR_EN
   logic last_dc;

   // Remember who won the most recent grant so the next tie goes the other way.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_dc <= 1'b0;
      end else if (grant_dc || grant_ic) begin
         last_dc <= grant_dc;
      end else begin
         last_dc <= last_dc;
      end
   end

   assign prefer_dc = ~last_dc;
`else
   assign prefer_dc = 1'b1;
`endif

   // Arbitration only in IDLE; outputs are forced quiet while reset is held.
   always_comb begin
      grant_dc = 1'b0;
      grant_ic = 1'b0;
      if (!reset && state == IDLE) begin
         grant_dc = dc_req_valid & (~ic_req_valid | prefer_dc);
         grant_ic = ic_req_valid & ~grant_dc;
      end else begin
         grant_dc = 1'b0;
         grant_ic = 1'b0;
      end
   end

   assign ic_req_ready    = grant_ic;
   assign dc_req_ready    = grant_dc;

   assign mem_req_valid   = ~reset & (state == ISSUE);
   assign mem_req_rw      = mem_req_valid & rw_lat;
   assign mem_req_addr    = mem_req_valid ? addr_lat : {ADDR_W{1'b0}};

   assign wdata_phase     = ~reset & (state == WDATA);
   assign resp_phase      = ~reset & (state == RESP);

   assign mem_wdata_valid = wdata_phase & dc_wdata_valid;
   assign dc_wdata_ready  = wdata_phase & mem_wdata_ready;
   assign mem_wdata       = wdata_phase ? dc_wdata : {DATA_W{1'b0}};

   assign ic_resp_valid   = resp_phase & ~owner_dc & mem_resp_valid;
   assign dc_resp_valid   = resp_phase & owner_dc & mem_resp_valid;
   assign ic_resp_data    = ic_resp_valid ? mem_resp_data : {DATA_W{1'b0}};
   assign dc_resp_data    = dc_resp_valid ? mem_resp_data : {DATA_W{1'b0}};

   assign beat_done       = (wdata_phase & dc_wdata_valid & mem_wdata_ready) |
                            (resp_phase & mem_resp_valid);

   // Transaction sequencer: grant, issue, then count write or read beats back to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner_dc <= 1'b0;
         rw_lat   <= 1'b0;
         addr_lat <= {ADDR_W{1'b0}};
         beat_cnt <= {CNT_W{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (grant_dc || grant_ic) begin
                  owner_dc <= grant_dc;
                  rw_lat   <= grant_dc & dc_req_rw;
                  addr_lat <= grant_dc ? dc_req_addr : ic_req_addr;
                  state    <= ISSUE;
               end else begin
                  state    <= IDLE;
               end
            end
            ISSUE: begin
               if (mem_req_ready) begin
                  beat_cnt <= {CNT_W{1'b0}};
                  state    <= rw_lat ? WDATA : RESP;
               end else begin
                  state    <= ISSUE;
               end
            end
            WDATA, RESP: begin
               if (beat_done) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
                  state    <= (beat_cnt == LAST_BEAT) ? IDLE : state;
               end else begin
                  beat_cnt <= beat_cnt;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_mem_arbiter;
   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;
   localparam int BEATS  = 4;
`ifdef MEM_ARB_RR_EN
   localparam int NT = 3;
`else
   localparam int NT = 2;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              ic_req_valid, dc_req_valid, dc_req_rw, dc_wdata_valid;
   logic              mem_req_ready, mem_wdata_ready, mem_resp_valid;
   logic [ADDR_W-1:0] ic_req_addr, dc_req_addr;
   logic [DATA_W-1:0] dc_wdata, mem_resp_data;
   logic              ic_req_ready, ic_resp_valid, dc_req_ready, dc_wdata_ready, dc_resp_valid;
   logic              mem_req_valid, mem_req_rw, mem_wdata_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [DATA_W-1:0] ic_resp_data, dc_resp_data, mem_wdata;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
      .clk(clk), .reset(reset),
      .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
      .dc_req_addr(dc_req_addr), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
      .dc_wdata(dc_wdata), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid),
      .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // Reference model: one outstanding transaction described as a record.
   bit                busy = 1'b0, issued = 1'b0, t_dc = 1'b0, t_rw = 1'b0, m_last_dc = 1'b0;
   logic [ADDR_W-1:0] t_addr = '0;
   int                nb = 0;

   // Observations for the directed literal expectations.
   int                ic_cnt = 0, dc_cnt = 0, stall_cnt = 0, ic_grant_dcb = -1;
   logic [127:0]      ic_q[$];
   logic [127:0]      wq[$];
   bit                gq[$];

   always @(negedge clk) begin : model_check
      logic              e_icr, e_dcr, e_mrv, e_mrw, e_mwv, e_dwr, e_icv, e_dcv, gdc, gic, xfer;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_mwd, e_icd, e_dcd;
      e_icr = 1'b0; e_dcr = 1'b0; e_mrv = 1'b0; e_mrw = 1'b0; e_mwv = 1'b0; e_dwr = 1'b0;
      e_icv = 1'b0; e_dcv = 1'b0; e_addr = '0; e_mwd = '0; e_icd = '0; e_dcd = '0;
`ifdef MEM_ARB_RR_EN
      gdc = dc_req_valid && (!ic_req_valid || !m_last_dc);
`else
      gdc = dc_req_valid;
`endif
      gic = ic_req_valid && !gdc;
      if (reset) begin
         e_icr = 1'b0;
      end else if (!busy) begin
         e_dcr = gdc;
         e_icr = gic;
      end else if (!issued) begin
         e_mrv = 1'b1; e_mrw = t_rw; e_addr = t_addr;
      end else if (t_rw) begin
         e_mwv = dc_wdata_valid; e_dwr = mem_wdata_ready; e_mwd = dc_wdata;
      end else if (t_dc) begin
         e_dcv = mem_resp_valid; e_dcd = mem_resp_valid ? mem_resp_data : '0;
      end else begin
         e_icv = mem_resp_valid; e_icd = mem_resp_valid ? mem_resp_data : '0;
      end
      chk("ic_req_ready", 128'(ic_req_ready), 128'(e_icr));
      chk("dc_req_ready", 128'(dc_req_ready), 128'(e_dcr));
      chk("mem_req_valid", 128'(mem_req_valid), 128'(e_mrv));
      chk("mem_req_rw", 128'(mem_req_rw), 128'(e_mrw));
      chk("mem_req_addr", 128'(mem_req_addr), 128'(e_addr));
      chk("mem_wdata_valid", 128'(mem_wdata_valid), 128'(e_mwv));
      chk("dc_wdata_ready", 128'(dc_wdata_ready), 128'(e_dwr));
      chk("mem_wdata", mem_wdata, e_mwd);
      chk("ic_resp_valid", 128'(ic_resp_valid), 128'(e_icv));
      chk("ic_resp_data", ic_resp_data, e_icd);
      chk("dc_resp_valid", 128'(dc_resp_valid), 128'(e_dcv));
      chk("dc_resp_data", dc_resp_data, e_dcd);

      if (ic_resp_valid) begin ic_cnt++; ic_q.push_back(ic_resp_data); end
      if (dc_resp_valid) dc_cnt++;
      if (mem_wdata_valid && mem_wdata_ready) wq.push_back(mem_wdata);
      if (dc_req_ready) gq.push_back(1'b1);
      if (ic_req_ready) begin gq.push_back(1'b0); ic_grant_dcb = dc_cnt; end
      if (mem_req_valid && !mem_req_ready && mem_req_addr == 28'h0ABCDEF && !mem_req_rw &&
          !ic_req_ready && !dc_req_ready) stall_cnt++;

      if (reset) begin
         busy = 1'b0; issued = 1'b0; m_last_dc = 1'b0;
      end else if (!busy) begin
         if (gdc || gic) begin
            busy = 1'b1; issued = 1'b0; t_dc = gdc; m_last_dc = gdc;
            t_rw = gdc ? dc_req_rw : 1'b0;
            t_addr = gdc ? dc_req_addr : ic_req_addr;
         end
      end else if (!issued) begin
         if (mem_req_ready) begin issued = 1'b1; nb = 0; end
      end else begin
         xfer = t_rw ? (dc_wdata_valid && mem_wdata_ready) : mem_resp_valid;
         if (xfer) begin
            nb++;
            if (nb == BEATS) busy = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ic_req_valid = 1'b0; dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_wdata_valid = 1'b0;
      mem_req_ready = 1'b0; mem_wdata_ready = 1'b0; mem_resp_valid = 1'b0;
      ic_req_addr = '0; dc_req_addr = '0; dc_wdata = '0; mem_resp_data = '0;
   endtask

   task automatic clear_obs();
      ic_cnt = 0; dc_cnt = 0; stall_cnt = 0; ic_grant_dcb = -1;
      ic_q.delete(); wq.delete(); gq.delete();
   endtask

   logic [127:0] rpat[4];
   logic [127:0] wpat[4];
   int acc;

   initial begin
      rpat[0] = 128'hAAAA_0000_1111_2222_3333_4444_5555_000A;
      rpat[1] = 128'hBBBB_0000_1111_2222_3333_4444_5555_000B;
      rpat[2] = 128'hCCCC_0000_1111_2222_3333_4444_5555_000C;
      rpat[3] = 128'hDDDD_0000_1111_2222_3333_4444_5555_000D;
      wpat[0] = 128'h0101_0101_0101_0101_0101_0101_0101_0101;
      wpat[1] = 128'h0202_0202_0202_0202_0202_0202_0202_0202;
      wpat[2] = 128'h0303_0303_0303_0303_0303_0303_0303_0303;
      wpat[3] = 128'h0404_0404_0404_0404_0404_0404_0404_0404;

      idle_inputs(); reset = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
      chk("reset_idle", 128'({ic_req_ready, dc_req_ready, mem_req_valid, mem_req_rw, mem_req_addr,
                              mem_wdata_valid, dc_wdata_ready, ic_resp_valid, dc_resp_valid}), 128'(0));

      // Icache line read with one gap cycle in the response stream.
      clear_obs();
      ic_req_valid = 1'b1; ic_req_addr = 28'h0000100; step();
      ic_req_valid = 1'b0; mem_req_ready = 1'b1; step();
      mem_req_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         mem_resp_valid = (i != 2);
         mem_resp_data = rpat[acc];
         step();
         if (i != 2) acc++;
      end
      idle_inputs(); step();
      chk("ic_read_beats", 128'(ic_cnt), 128'(4));
      for (int i = 0; i < 4; i++) chk("ic_read_data", (i < ic_q.size()) ? ic_q[i] : '1, rpat[i]);
      chk("ic_read_no_dc_resp", 128'(dc_cnt), 128'(0));

      // Dcache line write with mem_wdata_ready toggling.
      clear_obs();
      dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h0000200; step();
      dc_req_valid = 1'b0; dc_req_rw = 1'b0; mem_req_ready = 1'b1; step();
      mem_req_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 12 && acc < 4; k++) begin
         dc_wdata_valid = 1'b1; dc_wdata = wpat[acc]; mem_wdata_ready = (k % 2 == 0);
         mem_resp_valid = 1'b1; mem_resp_data = rpat[0];
         step();
         if (k % 2 == 0) acc++;
      end
      idle_inputs(); step();
      chk("dc_write_beats", 128'(wq.size()), 128'(4));
      for (int i = 0; i < 4; i++) chk("dc_write_data", (i < wq.size()) ? wq[i] : '1, wpat[i]);
      chk("dc_write_no_resp", 128'(ic_cnt + dc_cnt), 128'(0));

      // Simultaneous requests from a fresh reset.
      reset = 1'b1; step(); reset = 1'b0; step();
      clear_obs();
      ic_req_valid = 1'b1; dc_req_valid = 1'b1; dc_req_rw = 1'b0;
      ic_req_addr = 28'h0000300; dc_req_addr = 28'h0000400;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = rpat[1];
      for (int k = 0; k < 100 && gq.size() < NT; k++) begin
         step();
`ifndef MEM_ARB_RR_EN
         if (gq.size() >= 1) dc_req_valid = 1'b0;
`endif
      end
      ic_req_valid = 1'b0; dc_req_valid = 1'b0;
      for (int k = 0; k < 8; k++) step();
      idle_inputs(); step();
      chk("tie_grant_count", 128'(gq.size()), 128'(NT));
      for (int i = 0; i < NT; i++) chk("tie_grant_order", 128'((i < gq.size()) ? gq[i] : 1'bx), 128'(i % 2 == 0));
      chk("ic_grant_after_dc_done", 128'(ic_grant_dcb), 128'(4));

      // Memory holds off the request for 5 cycles while both caches keep requesting.
      clear_obs();
      ic_req_valid = 1'b1; ic_req_addr = 28'h0ABCDEF; step();
      dc_req_valid = 1'b1; dc_req_addr = 28'h0000777; ic_req_addr = 28'h0000666;
      for (int k = 0; k < 5; k++) step();
      ic_req_valid = 1'b0; dc_req_valid = 1'b0; mem_req_ready = 1'b1; step();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = rpat[2];
      for (int k = 0; k < 4; k++) step();
      idle_inputs(); step();
      chk("stall_stable_cycles", 128'(stall_cnt), 128'(5));
      chk("stall_then_read", 128'(ic_cnt), 128'(4));

      // Reset after two of four read beats; later beats must be ignored.
      clear_obs();
      ic_req_valid = 1'b1; ic_req_addr = 28'h0000500; step();
      ic_req_valid = 1'b0; mem_req_ready = 1'b1; step();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = rpat[3];
      step(); step();
      reset = 1'b1; step();
      reset = 1'b0;
      chk("post_reset_quiet", 128'({mem_req_valid, ic_resp_valid, dc_resp_valid, dc_wdata_ready}), 128'(0));
      step(); step();
      chk("reset_abandons_beats", 128'(ic_cnt), 128'(2));
      clear_obs();
      mem_resp_valid = 1'b0; ic_req_valid = 1'b1; ic_req_addr = 28'h0000600; step();
      ic_req_valid = 1'b0; mem_req_ready = 1'b1; step();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin mem_resp_data = rpat[k]; step(); end
      idle_inputs(); step();
      chk("read_after_reset", 128'(ic_cnt), 128'(4));

      // Randomized traffic with occasional resets, checked by the model every cycle.
      for (int k = 0; k < 4000; k++) begin
         reset           = ($urandom_range(199) == 0);
         ic_req_valid    = ($urandom_range(99) < 30);
         dc_req_valid    = ($urandom_range(99) < 30);
         dc_req_rw       = $urandom_range(1);
         ic_req_addr     = ADDR_W'($urandom);
         dc_req_addr     = ADDR_W'($urandom);
         dc_wdata_valid  = ($urandom_range(99) < 70);
         dc_wdata        = {$urandom, $urandom, $urandom, $urandom};
         mem_req_ready   = ($urandom_range(99) < 50);
         mem_wdata_ready = ($urandom_range(99) < 60);
         mem_resp_valid  = ($urandom_range(99) < 60);
         mem_resp_data   = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      reset = 1'b0; idle_inputs(); step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
